// File: rtl/poly1305_mac_engine.sv
// Streaming Poly1305 one-time authenticator: absorbs 16-byte blocks under a
// clamped r, reduces mod 2^130-5 and emits tag = (acc + s) mod 2^128.
module poly1305_mac_engine #(
  parameter int DIGIT_W    = 32,
  parameter bit CONST_TIME = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic         mode,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [127:0] blk_data,
  input  logic [4:0]   blk_len,
  input  logic         blk_last,
  input  logic         finish,
  input  logic [127:0] expected_tag,
  output logic         busy,
  output logic         tag_valid,
  output logic [127:0] tag,
  output logic         tag_ok
);
  // state | meaning
  // IDLE  | no session, blocks ignored
  // WAIT  | ready for a block or finish
  // MUL   | acc * r, one r digit per cycle (NDIG cycles)
  // RED   | two folds of bits >= 2^130 back in as *5
  // FINAL | full reduction, add s, compare
  // DONE  | one-cycle tag_valid
  localparam int NDIG = 128 / DIGIT_W;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  localparam logic [130:0] P = 131'h3_ffffffff_ffffffff_ffffffff_fffffffb;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MUL, S_RED, S_FINAL, S_DONE} state_t;
  state_t state, state_nx;

  logic [127:0] r, s, r_sh;
  logic [130:0] acc;
  logic [258:0] prod;
  logic [3:0]   mul_cnt;
  logic         red_cnt, last_q, mode_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_IDLE;
      S_WAIT:  if (blk_valid) state_nx = S_MUL;
               else if (finish) state_nx = S_FINAL;
      S_MUL:   if (mul_cnt == 4'd0) state_nx = S_RED;
      S_RED:   if (!red_cnt) state_nx = last_q ? S_FINAL : S_WAIT;
      S_FINAL: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (start) state_nx = S_WAIT;
  end

  assign blk_ready = (state == S_WAIT) && !start;
  assign busy      = (state == S_WAIT) || (state == S_MUL) || (state == S_RED) || (state == S_FINAL);
  assign tag_valid = (state == S_DONE);

  // Padded block: bytes below len, then a single 1 bit at 8*len.
  logic [4:0]   len_eff;
  logic [130:0] m_blk;
  always_comb begin
    len_eff = (blk_len == 5'd0 || blk_len > 5'd16) ? 5'd16 : blk_len;
    m_blk = '0;
    for (int i = 0; i < 16; i++)
      if (5'(i) < len_eff) m_blk[8*i +: 8] = blk_data[8*i +: 8];
    m_blk[{len_eff, 3'b000}] = 1'b1;
  end

  // Digits of r are taken MSB first, so the product is built Horner-style.
  logic [130+DIGIT_W:0] partial;
  logic [258:0]         prod_nx, fold;
  always_comb begin
    partial = {{DIGIT_W{1'b0}}, acc} * {131'b0, r_sh[127 -: DIGIT_W]};
    prod_nx = (prod << DIGIT_W) + {{(128-DIGIT_W){1'b0}}, partial};
    fold    = {130'b0, prod[258:130]} * 259'd5 + {129'b0, prod[129:0]};
  end

  logic [130:0] a1, a2;
  generate
    if (CONST_TIME) begin : g_ct
      logic [131:0] d1, d2;
      always_comb begin
        d1 = {1'b0, acc} - {1'b0, P};
        a1 = (acc & {131{d1[131]}}) | (d1[130:0] & {131{~d1[131]}});
        d2 = {1'b0, a1} - {1'b0, P};
        a2 = (a1 & {131{d2[131]}}) | (d2[130:0] & {131{~d2[131]}});
      end
    end else begin : g_var
      always_comb begin
        a1 = (acc >= P) ? acc - P : acc;
        a2 = (a1 >= P) ? a1 - P : a1;
      end
    end
  endgenerate

  logic [127:0] tag_calc;
  logic [2:0]   unused_hi;
  assign tag_calc  = a2[127:0] + s;
  assign unused_hi = a2[130:128];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r       <= '0;
      s       <= '0;
      r_sh    <= '0;
      acc     <= '0;
      prod    <= '0;
      mul_cnt <= '0;
      red_cnt <= 1'b0;
      last_q  <= 1'b0;
      mode_q  <= 1'b0;
      tag     <= '0;
      tag_ok  <= 1'b0;
    end else if (start) begin
      r      <= key_in[127:0] & CLAMP;
      s      <= key_in[255:128];
      acc    <= '0;
      mode_q <= mode;
      tag_ok <= 1'b0;
      last_q <= 1'b0;
    end else begin
      case (state)
        S_WAIT: if (blk_valid) begin
          acc     <= acc + m_blk;
          last_q  <= blk_last | finish;
          prod    <= '0;
          r_sh    <= r;
          mul_cnt <= 4'(NDIG - 1);
        end
        S_MUL: begin
          prod    <= prod_nx;
          r_sh    <= r_sh << DIGIT_W;
          red_cnt <= 1'b1;
          if (mul_cnt != 4'd0) mul_cnt <= mul_cnt - 4'd1;
        end
        S_RED: begin
          prod <= fold;
          if (red_cnt) red_cnt <= 1'b0;
          else         acc     <= fold[130:0];
        end
        S_FINAL: begin
          tag    <= tag_calc;
          tag_ok <= mode_q && (tag_calc == expected_tag);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/poly1305_mac_engine.md
Name: poly1305_mac_engine

Overview:
- Parametrised, streaming Poly1305 one-time authenticator (RFC 8439) for the ChaCha20-Poly1305 datapath.
- Takes a 256-bit one-time key (r||s, normally ChaCha20 block 0), then absorbs a message as 16-byte blocks with valid/ready handshake.
- Blocks may be partial; block length is explicit.
- Produces a 128-bit tag, and optionally compares it against an expected tag for decrypt-side verification.
- Replaces the fixed, unpadded accumulate path with proper clamping, padding, final reduction and a tunable multiplier digit width.

Parameters:
- DIGIT_W, 32: multiplier digit width in bits. Legal values are 8, 16, 32, 64. r is consumed in NDIG = 128/DIGIT_W digits, one per cycle.
- CONST_TIME, 1: when 1, the final conditional subtract always executes both paths and selects the result (no data-dependent timing).

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous active-low reset.
- start, input, 1: one-cycle pulse. Loads key_in and mode, clears the accumulator.
- key_in, input, 256: one-time key, little-endian. Byte 0 is key_in[7:0]; r = bytes 0..15, s = bytes 16..31.
- mode, input, 1: 0 = generate, 1 = verify. Sampled on start.
- blk_valid, input, 1: message block offered.
- blk_ready, output, 1: engine can accept a block.
- blk_data, input, 128: block bytes, little-endian. Bytes at index >= blk_len are ignored.
- blk_len, input, 5: byte count 1..16. Values 0 and 17..31 are treated as 16.
- blk_last, input, 1: qualifies the accepted block as final. Finalisation follows that block.
- finish, input, 1: finalise with no further block (used for empty messages).
- expected_tag, input, 128: compare value in verify mode. Sampled when finalisation starts.
- busy, output, 1: high from start until tag_valid.
- tag_valid, output, 1: one-cycle pulse.
- tag, output, 128: result. Held stable until the next start.
- tag_ok, output, 1: valid with tag_valid. 1 iff mode=1 and tag == expected_tag; always 0 in generate mode.

Behaviour:
- Reset (async, any state):
  - State returns to IDLE.
  - Accumulator, r and s are cleared.
  - blk_ready=0, busy=0, tag_valid=0, tag=0, tag_ok=0.
  - No partial result survives reset.
- States: IDLE, WAIT, MUL, RED, FINAL, DONE.
- IDLE:
  - blk_ready=0.
  - start moves to WAIT.
  - blk_valid and finish are ignored.
- start, accepted in any state, including mid-block:
  - r <= key_in[127:0] & 0x0ffffffc0ffffffc0ffffffc0fffffff.
  - s <= key_in[255:128]; acc <= 0; mode latched; tag_ok cleared.
  - Any in-flight block is abandoned. State moves to WAIT on the next cycle.
- WAIT:
  - blk_ready=1.
  - A transfer occurs when blk_valid && blk_ready. Then:
    - m = masked blk_data + 2^(8*len), 131 bits wide.
    - acc <= acc + m.
    - Move to MUL.
    - blk_last is latched with the block.
  - finish with no blk_valid moves to FINAL.
  - blk_valid and finish in the same cycle: the block is taken and finish is treated as blk_last.
- MUL:
  - NDIG cycles. Each cycle: product += acc * r_digit[i] << (i*DIGIT_W).
  - Product width is 259 bits.
  - blk_ready=0.
- RED:
  - 2 cycles. Each cycle folds bits above 130 as hi*5 + lo, giving acc < 2^130 + small.
  - Full reduction below p is not required here.
  - Exits to FINAL if the latched blk_last is set, otherwise to WAIT.
- Block throughput: accept at cycle T, blk_ready high again at T+NDIG+3. For DIGIT_W=32 that is T+7.
- FINAL (1 cycle):
  - Full reduction: if acc >= p = 2^130-5 then acc -= p. This runs at most twice, resolved combinationally.
  - tag <= (acc + s) mod 2^128.
  - expected_tag is compared.
- DONE:
  - tag_valid=1 for exactly one cycle; busy drops in the same cycle.
  - Then returns to IDLE. tag and tag_ok hold until the next start.
- Empty message: finish in WAIT gives tag = s.
- Simultaneous events:
  - start beats blk_valid, finish and blk_last in the same cycle.
  - blk_valid outside WAIT is not accepted; the source must hold it.
- All datapath adds are modular as stated. The accumulator register is 131 bits; no overflow beyond that is possible given the clamped r.

Test Plan:
1. RFC 8439 §2.5.2: key 85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b (byte order as listed), message "Cryptographic Forum Research Group" sent as 16 + 16 + 2-byte blocks, last on the third, mode=0 -> tag bytes a8061dc1305136c6c22b8baf0c0127a9, tag_ok=0, one tag_valid pulse.
2. Same vector, mode=1, expected_tag equal to the above -> tag_ok=1. Flip expected_tag bit 0 -> tag_ok=0 and tag unchanged.
3. Empty message: start with s = 0x0123…ef, then finish -> tag == s, tag_valid 2 cycles after finish.
4. Throughput and backpressure, DIGIT_W=32: blk_valid held high continuously -> blk_ready high once every 7 cycles. Rebuild with DIGIT_W=8 -> once every 19 cycles; tags identical.
5. Overflow boundary: r = all-ones before clamp, 16-byte blocks of 0xff repeated 64 times -> tag matches the software model, exercising the final subtract of p.
6. Abort: start mid-MUL with a new key, then replay test 1 -> correct tag. Assert reset_n mid-block -> all outputs 0 within the same cycle (async).
